rr3_slot_arbiter: RTL and testbench
===================================

Name: rr3_slot_arbiter

Overview:
- Round-robin arbiter that shares one resource between three requesters.
- Uses a registered one-hot grant, a bounded hold time, and a mandatory one-cycle turnaround gap between owners.
- Priority rotates through the ring 0→1→2→0. The pointer advances past each winner, so every continuously requesting client is served within 3 grants.
- Sits in front of any shared unit, such as a bus, display mux or counter block, that must serve at most one client at a time.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership. Legal range is 1..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  3  per-requester request. The requester holds it high for as long as it needs the resource.
- grant  output  3  one-hot registered grant, or 000 when the resource is idle.
- owner  output  2  index of the current grant holder. Meaningful only while busy=1; otherwise 2'b00.
- busy  output  1  high while any grant bit is high.
- timeout  output  1  one-cycle pulse when an ownership is force-ended by MAX_HOLD.

Behaviour:
- Clocking and reset:
  - Single clock domain. All outputs are registered.
  - Reset is asynchronous and active-high. It immediately forces state=IDLE, grant=000, owner=00, busy=0, timeout=0, ptr=0 and hold_cnt=0.
  - A reset mid-grant drops the grant at once, without waiting for a clock edge.
- States:
  - IDLE: no owner; arbitrates.
  - GRANT: one owner holds the resource.
  - GAP: one-cycle turnaround; grant=000, and the block arbitrates during this cycle.
- Arbitration (in IDLE and GAP):
  - Search order is ptr, ptr+1, ptr+2, taken mod 3.
  - The first requester found with req high wins.
  - On the next edge: grant=onehot(winner), owner=winner, busy=1, hold_cnt=0, ptr=(winner+1) mod 3, state=GRANT.
  - If no requester is high: IDLE stays IDLE, GAP goes to IDLE, and ptr is unchanged.
- Latency:
  - From IDLE, grant rises on the first edge at which req is sampled high.
  - Back-to-back owners are always separated by exactly one grant=000 cycle (the GAP).
- GRANT behaviour, evaluated each cycle:
  - If req[owner]=0, the next edge gives grant=000, busy=0, state=GAP. This is a normal release.
  - Else if hold_cnt=MAX_HOLD-1, the next edge gives grant=000, busy=0, timeout=1 (for the GAP cycle only), state=GAP. This is a forced release.
  - Else hold_cnt increments and the grant is held.
  - req bits of non-owners are ignored during GRANT.
- Hold limits:
  - A continuously requesting owner sees grant high for exactly MAX_HOLD cycles.
  - With MAX_HOLD=1, every grant lasts exactly one cycle.
- Release timing: because grant is registered, grant stays high for one cycle after the owner drops req.
- Timed-out requester:
  - It re-enters arbitration in the GAP cycle, at the lowest priority because ptr has already passed it.
  - If it is the only requester, it is re-granted immediately after the one GAP cycle.
- Output invariants:
  - grant is always 000 or exactly one-hot.
  - busy equals the OR of the grant bits.
  - owner never changes while busy=1.
- Deasserting req while in GAP simply removes that requester from arbitration.
- Illegal state encodings recover to IDLE with grant=000 on the next edge.

Test Plan:
All scenarios use MAX_HOLD=4 and start from reset released with ptr=0.
1. Reset state: assert reset mid-GRANT between clock edges → grant=000, busy=0, timeout=0 immediately, not waiting for an edge. After reset deasserts, req=010 → grant=010, owner=1 at the first edge.
2. Round robin:
   - Stimulus: req=111 held constant.
   - Required grant sequence: 001×4, 000, 010×4, 000, 100×4, 000, 001.
   - timeout pulses in each of the three GAP cycles.
3. Early release:
   - Stimulus: req=001 for 2 cycles after grant, then req=000.
   - Required response: grant=001 for 3 cycles, then 000 for one GAP cycle, then IDLE.
   - timeout stays 0 and ptr=1.
4. Lone timed-out requester: req=100 held → grant=100×4, timeout=1 with grant=000 for 1 cycle, then grant=100×4 again.
5. Pointer fairness:
   - Stimulus: ptr=2 after a grant to client 1, then req=011 arrives in IDLE.
   - Required response: client 0 wins (search order 2,0,1).
   - Next round with req=011 held: client 1 wins.
6. Non-owner noise: while client 0 owns, toggle req[2:1] every cycle → grant stays 001 and owner stays 0 until client 0 releases or MAX_HOLD is reached.

Source files
------------

// File: rtl/rr3_slot_arbiter.sv
// Three-way round-robin arbiter with a registered one-hot grant, bounded hold
// time and a mandatory one-cycle turnaround gap between successive owners.
module rr3_slot_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N_REQ = 3;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [1:0]       owner_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;

    logic [1:0]       p0, p1, p2;
    logic [1:0]       win;
    logic [1:0]       win_ptr;
    logic             found;
    logic             owner_req;

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        ring_next = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Rotating search starting at ptr; a corrupt ptr value is treated as 0.
    always_comb begin
        p0      = (ptr == 2'd3) ? 2'd0 : ptr;
        p1      = ring_next(p0);
        p2      = ring_next(p1);
        found   = |req;
        win     = p2;
        if (|(req & onehot(p0))) begin
            win = p0;
        end else if (|(req & onehot(p1))) begin
            win = p1;
        end
        win_ptr = ring_next(win);
    end

    // The registered grant is one-hot, so masking req with it selects req[owner].
    assign owner_req = |(req & grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            owner    <= owner_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = '0;
        owner_nxt   = 2'd0;
        busy_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_nxt = GRANT;
                    grant_nxt = onehot(win);
                    owner_nxt = win;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                    ptr_nxt   = win_ptr;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nxt = GAP;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = GAP;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt + CNT_W'(1);
                    grant_nxt = grant;
                    owner_nxt = owner;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr3_slot_arbiter.sv
// Directed self-checking bench for rr3_slot_arbiter with MAX_HOLD=4; inputs
// change and outputs are sampled on the falling clock edge.
module tb_rr3_slot_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_assert;
    int n_fail;

    rr3_slot_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] eg, input logic [1:0] eo,
                         input logic eb, input logic et);
        n_assert++;
        assert (grant === eg) else begin
            n_fail++;
            $error("FAIL %s grant=%b expected %b", tag, grant, eg);
        end
        n_assert++;
        assert (owner === eo) else begin
            n_fail++;
            $error("FAIL %s owner=%0d expected %0d", tag, owner, eo);
        end
        n_assert++;
        assert (busy === eb) else begin
            n_fail++;
            $error("FAIL %s busy=%b expected %b", tag, busy, eb);
        end
        n_assert++;
        assert (timeout === et) else begin
            n_fail++;
            $error("FAIL %s timeout=%b expected %b", tag, timeout, et);
        end
    endtask

    // Leaves the bench at a falling edge with reset just released and req=000.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        check("reset_hold", 3'b000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] eg;
        logic [1:0] eo;
        logic [1:0] noise;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 3'b000;

        // 1: asynchronous reset mid-grant, then first grant after release
        do_reset();
        req = 3'b001;
        @(negedge clk);
        check("s1_grant0", 3'b001, 2'd0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check("s1_async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req   = 3'b010;
        @(negedge clk);
        check("s1_first_edge", 3'b010, 2'd1, 1'b1, 1'b0);

        // 2: all three requesting, four-cycle holds with timeout gaps
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            eo = 2'((k / 5) % 3);
            if (k % 5 < 4) begin
                eg = 3'b001 << eo;
                check($sformatf("s2_rr_%0d", k), eg, eo, 1'b1, 1'b0);
            end else begin
                check($sformatf("s2_rr_%0d", k), 3'b000, 2'd0, 1'b0, 1'b1);
            end
        end

        // 3: early release, then ptr=1 shows through a 011 request
        do_reset();
        req = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("s3_hold_%0d", k), 3'b001, 2'd0, 1'b1, 1'b0);
        end
        req = 3'b000;
        @(negedge clk);
        check("s3_gap", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("s3_idle", 3'b000, 2'd0, 1'b0, 1'b0);
        req = 3'b011;
        @(negedge clk);
        check("s3_ptr1", 3'b010, 2'd1, 1'b1, 1'b0);

        // 4: lone requester is re-granted after one timeout gap
        do_reset();
        req = 3'b100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 4) check("s4_gap", 3'b000, 2'd0, 1'b0, 1'b1);
            else        check($sformatf("s4_hold_%0d", k), 3'b100, 2'd2, 1'b1, 1'b0);
        end

        // 5: ptr=2 after client 1, so 011 picks client 0 then client 1
        do_reset();
        req = 3'b010;
        @(negedge clk);
        check("s5_c1", 3'b010, 2'd1, 1'b1, 1'b0);
        req = 3'b000;
        @(negedge clk);
        check("s5_gap", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("s5_idle", 3'b000, 2'd0, 1'b0, 1'b0);
        req = 3'b011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4)       check($sformatf("s5_c0_%0d", k), 3'b001, 2'd0, 1'b1, 1'b0);
            else if (k == 4) check("s5_gap2", 3'b000, 2'd0, 1'b0, 1'b1);
            else             check("s5_c1_next", 3'b010, 2'd1, 1'b1, 1'b0);
        end

        // 6: non-owner request noise does not disturb the owner
        do_reset();
        req   = 3'b001;
        noise = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s6_noise_%0d", k), 3'b001, 2'd0, 1'b1, 1'b0);
            req   = {noise, 1'b1};
            noise = noise ^ ((k % 2 == 0) ? 2'b11 : 2'b10);
        end
        @(negedge clk);
        check("s6_timeout", 3'b000, 2'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
